// File: rtl/seg_scan_ctrl8_if.sv
// Bus bundle for the 8-digit scan controller: frame/scan controls in,
// per-digit display outputs back.
interface seg_scan_ctrl8_if;
  logic        en;
  logic [31:0] data;
  logic [7:0]  dp;
  logic        blank_lz;
  logic [2:0]  sel;
  logic [3:0]  nibble;
  logic        dp_out;
  logic        digit_on;
  logic        tick;

  modport master (
    output en, data, dp, blank_lz,
    input  sel, nibble, dp_out, digit_on, tick
  );

  modport slave (
    input  en, data, dp, blank_lz,
    output sel, nibble, dp_out, digit_on, tick
  );
endinterface

// File: rtl/seg_scan_ctrl8.sv
// Time-multiplexed scan controller for an 8-digit display: prescaled digit
// stepping, tear-free frame snapshot and leading-zero blanking.
module seg_scan_ctrl8 #(
  parameter int DIV = 100000
) (
  input  logic           clk,
  input  logic           rst,
  seg_scan_ctrl8_if.slave bus
);
  localparam int            CW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_reg, cnt_next;
  logic [2:0]    sel_reg, sel_next;
  logic [31:0]   sh_data_reg, sh_data_next;
  logic [7:0]    sh_dp_reg, sh_dp_next;
  logic [3:0]    nibble_reg, nibble_next;
  logic          dp_out_reg, dp_out_next;
  logic          digit_on_reg, digit_on_next;
  logic          tick_reg;
  logic          step;
  logic [7:0]    upper_zero;

  assign step = bus.en && (cnt_reg == CNT_LAST);

  always_comb begin
    cnt_next = cnt_reg;
    if (bus.en) begin
      cnt_next = (cnt_reg == CNT_LAST) ? '0 : cnt_reg + 1'b1;
    end
  end

  assign sel_next = step ? sel_reg + 3'd1 : sel_reg;

  // New frame is captured on the 7->0 step, and continuously while idle.
  always_comb begin
    sh_data_next = sh_data_reg;
    sh_dp_next   = sh_dp_reg;
    if (!bus.en || (step && sel_reg == 3'd7)) begin
      sh_data_next = bus.data;
      sh_dp_next   = bus.dp;
    end
  end

  // upper_zero[i]: shadow nibbles i..7 are all zero.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_upper_zero
      assign upper_zero[gi] = ~|sh_data_next[31:4*gi];
    end
  endgenerate

  // Outputs are built from the post-edge shadow so digit 0 shows the new frame.
  always_comb begin
    nibble_next   = nibble_reg;
    dp_out_next   = dp_out_reg;
    digit_on_next = digit_on_reg;
    if (step) begin
      digit_on_next = (sel_next == 3'd0) || !bus.blank_lz || !upper_zero[sel_next];
      nibble_next   = digit_on_next ? sh_data_next[{sel_next, 2'b00} +: 4] : 4'd0;
      dp_out_next   = digit_on_next && sh_dp_next[sel_next];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg      <= '0;
      sel_reg      <= '0;
      sh_data_reg  <= '0;
      sh_dp_reg    <= '0;
      nibble_reg   <= '0;
      dp_out_reg   <= 1'b0;
      digit_on_reg <= 1'b0;
      tick_reg     <= 1'b0;
    end else begin
      cnt_reg      <= cnt_next;
      sel_reg      <= sel_next;
      sh_data_reg  <= sh_data_next;
      sh_dp_reg    <= sh_dp_next;
      nibble_reg   <= nibble_next;
      dp_out_reg   <= dp_out_next;
      digit_on_reg <= digit_on_next;
      tick_reg     <= step;
    end
  end

  assign bus.sel      = sel_reg;
  assign bus.nibble   = nibble_reg;
  assign bus.dp_out   = dp_out_reg;
  assign bus.digit_on = digit_on_reg;
  assign bus.tick     = tick_reg;
endmodule

// File: doc/seg_scan_ctrl8.md
# seg_scan_ctrl8

Time-multiplexed scan controller for an 8-digit display. It divides the system clock into a digit-scan rate and steps a 3-bit digit index 0→7 cyclically. For each step it presents the current digit's hex nibble, decimal point and blanking flag. The `sel` output drives the 3-to-8 one-hot decoder directly (digit-enable stage), and `nibble` feeds the segment encoder.

## Interface
- `DIV`, default 100000: prescaler terminal count, in clock cycles per digit step. Legal range ≥ 1. The counter width is `$clog2(DIV)` (minimum 1).
- `clk`, input, 1: system clock; all state updates on the rising edge.
- `rst`, input, 1: reset, asynchronous and active-high; clears all state immediately.
- `en`, input, 1: scan enable.
- `data`, input, 32: eight hex digits; digit i = `data[4i+3:4i]`; digit 7 is most significant.
- `dp`, input, 8: decimal point per digit; bit i belongs to digit i.
- `blank_lz`, input, 1: leading-zero blanking enable.
- `sel`, output, 3: current digit index, to the 3-to-8 decoder.
- `nibble`, output, 4: hex value of the current digit.
- `dp_out`, output, 1: decimal point of the current digit.
- `digit_on`, output, 1: 1 = current digit lit, 0 = blanked.
- `tick`, output, 1: one-cycle pulse marking an index step.

## Operation
- **Prescaler.** `cnt` counts 0..DIV-1 while `en`=1. When `cnt`=DIV-1 it wraps to 0 and the step condition fires. When `en`=0, `cnt` holds.
- **Step.** `sel` ← (`sel`+1) mod 8, so 7 wraps to 0. `tick` is 1 for exactly that cycle.
- **Frame snapshot.**
  - Shadow registers `sh_data[31:0]` and `sh_dp[7:0]` hold the displayed frame.
  - They load `data`/`dp` on the step that moves `sel` from 7 to 0.
  - They also load every cycle while `en`=0.
  - Otherwise they hold, so mid-frame changes to `data` never tear a frame.
- **Output registers.**
  - On a step, `nibble`, `dp_out` and `digit_on` are loaded for the new index.
  - They use the shadow value valid after that edge, so digit 0 of a new frame shows the newly captured data.
  - Between steps, and while `en`=0, all outputs hold.
- **Leading-zero blanking.**
  - For index i ≥ 1: digit i is blanked (`digit_on`=0) when `blank_lz`=1 and shadow nibbles i..7 are all zero.
  - Digit 0 is never blanked.
  - With `blank_lz`=0, every digit has `digit_on`=1.
- **Blanked digit.** `nibble`=0 and `dp_out`=0.
- **Lit digit.** `nibble`=`sh_data[4·sel+3:4·sel]` and `dp_out`=`sh_dp[sel]`.
- **Blanking input timing.** `blank_lz` is sampled at each step and is not snapshotted.

## Timing
- **Reset values.** `sel`=0, `nibble`=0, `dp_out`=0, `digit_on`=0, `tick`=0. Internal `cnt`=0, `sh_data`=0, `sh_dp`=0.
- **After reset.** Outputs are meaningful from the first `tick`. The first step after reset shows index 1.
- **Step latency.** With `en` held at 1 from reset release, the first `tick` occurs on the DIV-th rising edge. After that, steps recur every DIV cycles.
- **Output alignment.** `sel`, `nibble`, `dp_out`, `digit_on` and `tick` all change on the same edge; there is no skew between them.
- **DIV=1.** A step occurs on every enabled cycle, and `tick` stays high continuously while `en`=1.
- **`en` falling mid-count.** `cnt` and `sel` freeze and `tick`=0. When `en` rises again, counting resumes from the frozen `cnt`, so the remaining cycles of that step are preserved.
- **`en` rising on the same edge the count would hit DIV-1.** No special case: the step fires only on an edge where `en`=1 and `cnt`=DIV-1.
- **`rst` asserted mid-operation.** Outputs go to their reset values without waiting for `clk`. After release, behaviour is as after power-up.
- **Outputs.** All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- DIV=4, `en`=1, `data`=32'h76543210, `dp`=8'h00, `blank_lz`=0 → `tick` every 4 cycles; `sel` runs 1,2,…,7,0,1; `nibble`==`sel` each step; `digit_on`=1 throughout.
- DIV=2, `blank_lz`=1, `data`=32'h00000A05, `dp`=8'h04 → digits 0,1,2 show 5,0,A with `digit_on`=1 and `dp_out`=1 on digit 2 only; digits 3–7 show `digit_on`=0, `nibble`=0. Then `data`=0 → only digit 0 is lit, showing 0.
- DIV=3, frame running with `data`=32'h11111111; at `sel`=3 change `data` to 32'h22222222 → digits 4–7 show 1; after the 7→0 wrap, digits 0–7 show 2.
- DIV=5, drop `en` for 10 cycles when `sel`=5 and `cnt`=2 → no `tick` and `sel` stays 5; after `en` returns, the next `tick` arrives 3 cycles later with `sel`=6.
- DIV=1, `en`=1 → `tick` stays high continuously; `sel` increments every cycle and wraps 7→0.
- Assert `rst` between clock edges while `sel`=6 and `digit_on`=1 → all outputs read 0 before the next edge; after release with DIV=4, the first `tick` occurs 4 edges later with `sel`=1.
